// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field definitions and rounding-mode codes
// for the fixed-point to float conversion path.
package fp_pkg;

  localparam int FP_BIAS     = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MANT_W   = 23;

  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_RNE   = 1;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/lead_one_detect.sv
// Combinational leading-one detector.
//   mag  : input word, W bits
//   pos  : index of the most-significant set bit (0 when mag is zero)
//   zero : mag == 0
module lead_one_detect #(
  parameter  int W     = 20,
  localparam int POS_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     mag,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) pos = POS_W'(i);
    end
  end

  assign zero = (mag == '0);

endmodule

// File: rtl/fixed_to_fp_pipe.sv
// Three-stage streaming converter from sign-magnitude fixed point
// (INT_W integer bits, FRAC_W fraction bits) to IEEE-754 single precision.
//   clk, reset       : clock, synchronous active-high reset
//   valid_i/ready_o  : input handshake; sign_i, mag_i carry the word
//   valid_o/ready_i  : output handshake; fp_o carries the packed float
// Each stage advances when empty or when the stage after it advances, so
// bubbles collapse under backpressure and full throughput is one word/cycle.
module fixed_to_fp_pipe
  import fp_pkg::*;
#(
  parameter int INT_W      = 1,
  parameter int FRAC_W     = 19,
  parameter int ROUND_MODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    sign_i,
  input  logic [INT_W+FRAC_W-1:0] mag_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             fp_o
);

  localparam int MAG_W  = INT_W + FRAC_W;
  localparam int POS_W  = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  // Magnitude padded below with mantissa + guard zeros so every field slice
  // stays in range even for very narrow magnitudes.
  localparam int NORM_W = MAG_W + FP_MANT_W + 2;

  function automatic logic [FP_EXP_W-1:0] calc_exp(input logic [POS_W-1:0] p);
    return FP_EXP_W'(FP_BIAS + int'(p) - FRAC_W);
  endfunction

  function automatic fp32_t round_pack(
    input logic                 sign,
    input logic [FP_EXP_W-1:0]  exp,
    input logic [FP_MANT_W-1:0] mant,
    input logic                 guard,
    input logic                 sticky,
    input logic                 zero
  );
    logic         inc;
    logic [FP_MANT_W:0] sum;
    fp32_t        r;
    inc    = (ROUND_MODE == ROUND_RNE) && guard && (sticky || mant[0]);
    sum    = {1'b0, mant} + {{FP_MANT_W{1'b0}}, inc};
    r.sign = sign;
    // A carry out of the mantissa leaves the low bits all zero already.
    r.exp  = sum[FP_MANT_W] ? exp + 8'd1 : exp;
    r.mant = sum[FP_MANT_W-1:0];
    if (zero) r = '0;
    return r;
  endfunction

  logic                  vld_p0, vld_p1, vld_p2;
  logic                  adv_p0, adv_p1, adv_p2;

  logic                  sign_p0, zero_p0;
  logic [MAG_W-1:0]      mag_p0;
  logic [POS_W-1:0]      pos_p0;

  logic                  sign_p1, zero_p1, guard_p1, sticky_p1;
  logic [FP_EXP_W-1:0]   exp_p1;
  logic [FP_MANT_W-1:0]  mant_p1;

  fp32_t                 fp_p2;

  logic [POS_W-1:0]      pos_n;
  logic                  zero_n;
  logic [NORM_W-2:0]     norm;
  int                    sh;

  assign adv_p2  = ~vld_p2 | ready_i;
  assign adv_p1  = ~vld_p1 | adv_p2;
  assign adv_p0  = ~vld_p0 | adv_p1;
  assign ready_o = adv_p0;
  assign valid_o = vld_p2;
  assign fp_o    = fp_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= valid_i;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // S1: capture + leading-one detect
  lead_one_detect #(.W(MAG_W)) u_lod (
    .mag  (mag_i),
    .pos  (pos_n),
    .zero (zero_n)
  );

  always_ff @(posedge clk) begin
    if (adv_p0 && valid_i) begin
      sign_p0 <= sign_i;
      mag_p0  <= mag_i;
      pos_p0  <= pos_n;
      zero_p0 <= zero_n;
    end
  end

  // S2: normalise -- leading one shifted out past the top of norm
  always_comb begin
    sh   = MAG_W - int'(pos_p0);
    norm = (NORM_W-1)'({1'b0, mag_p0, {(FP_MANT_W+1){1'b0}}} << sh);
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && vld_p0) begin
      sign_p1   <= sign_p0;
      zero_p1   <= zero_p0;
      exp_p1    <= calc_exp(pos_p0);
      mant_p1   <= norm[NORM_W-2 -: FP_MANT_W];
      guard_p1  <= norm[MAG_W];
      sticky_p1 <= |norm[MAG_W-1:0];
    end
  end

  // S3: round + pack into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      fp_p2 <= '0;
    end else if (adv_p2 && vld_p1) begin
      fp_p2 <= round_pack(sign_p1, exp_p1, mant_p1, guard_p1, sticky_p1, zero_p1);
    end
  end

endmodule

// File: tb/tb_fixed_to_fp_pipe.sv
module tb_fixed_to_fp_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        sign_i;
  logic        ready_i;
  logic [31:0] mag;

  logic        rdy_def, rdy_rne, rdy_trc;
  logic        vo_def, vo_rne, vo_trc;
  logic [31:0] fp_def, fp_rne, fp_trc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_to_fp_pipe u_def (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_def),
    .sign_i(sign_i), .mag_i(mag[19:0]), .valid_o(vo_def), .ready_i(ready_i),
    .fp_o(fp_def)
  );

  fixed_to_fp_pipe #(.INT_W(2), .FRAC_W(30), .ROUND_MODE(1)) u_rne (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_rne),
    .sign_i(sign_i), .mag_i(mag), .valid_o(vo_rne), .ready_i(ready_i),
    .fp_o(fp_rne)
  );

  fixed_to_fp_pipe #(.INT_W(2), .FRAC_W(30), .ROUND_MODE(0)) u_trc (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_trc),
    .sign_i(sign_i), .mag_i(mag), .valid_o(vo_trc), .ready_i(ready_i),
    .fp_o(fp_trc)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One word through an empty pipeline; use_m selects {def, rne, trc} results to check.
  task automatic run_vec(input string tag, input logic s, input logic [31:0] m,
                         input logic [2:0] use_m, input logic [31:0] e_def,
                         input logic [31:0] e_rne, input logic [31:0] e_trc);
    sign_i  = s;
    mag     = m;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk({tag, "_lat1"}, 32'({vo_def, vo_rne, vo_trc}), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 32'({vo_def, vo_rne, vo_trc}), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'({vo_def, vo_rne, vo_trc}), 32'd7);
    if (use_m[2]) chk({tag, "_def"}, fp_def, e_def);
    if (use_m[1]) chk({tag, "_rne"}, fp_rne, e_rne);
    if (use_m[0]) chk({tag, "_trc"}, fp_trc, e_trc);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_mag [6] = '{32'h80000, 32'h40000, 32'h00001, 32'hC0000, 32'h20000, 32'hFFFFF};
  logic        bp_sgn [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] bp_exp [6] = '{32'h3F80_0000, 32'hBF00_0000, 32'h3600_0000,
                              32'h3FC0_0000, 32'hBE80_0000, 32'h3FFF_FFF0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    sign_i  = 1'b0;
    ready_i = 1'b1;
    mag     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'({vo_def, vo_rne, vo_trc}), 32'd0);
    chk("rst_fp", fp_def | fp_rne | fp_trc, 32'd0);
    reset = 1'b0;
    chk("rst_ready", 32'({rdy_def, rdy_rne, rdy_trc}), 32'd7);

    run_vec("one",        1'b0, 32'h0008_0000, 3'b100, 32'h3F80_0000, 32'h0, 32'h0);
    run_vec("neg_half",   1'b1, 32'h0004_0000, 3'b100, 32'hBF00_0000, 32'h0, 32'h0);
    run_vec("lsb",        1'b0, 32'h0000_0001, 3'b100, 32'h3600_0000, 32'h0, 32'h0);
    run_vec("max_def",    1'b0, 32'h000F_FFFF, 3'b100, 32'h3FFF_FFF0, 32'h0, 32'h0);
    run_vec("neg_zero",   1'b1, 32'h0000_0000, 3'b111, 32'h0, 32'h0, 32'h0);
    run_vec("ones_wide",  1'b0, 32'hFFFF_FFFF, 3'b011, 32'h0, 32'h4080_0000, 32'h407F_FFFF);
    run_vec("tie_even",   1'b0, 32'h8000_0080, 3'b011, 32'h0, 32'h4000_0000, 32'h4000_0000);
    run_vec("tie_odd",    1'b0, 32'h8000_0180, 3'b011, 32'h0, 32'h4000_0002, 32'h4000_0001);
    run_vec("above_tie",  1'b0, 32'h8000_0081, 3'b011, 32'h0, 32'h4000_0001, 32'h4000_0000);
    run_vec("small_wide", 1'b1, 32'h0000_0003, 3'b011, 32'h0, 32'hB140_0000, 32'hB140_0000);

    // Backpressure: six words back-to-back, ready_i low for cycles 2..8.
    fork
      begin : drv
        for (int i = 0; i < 6; i++) begin
          logic acc;
          sign_i  = bp_sgn[i];
          mag     = bp_mag[i];
          valid_i = 1'b1;
          acc     = 1'b0;
          while (!acc) begin
            @(negedge clk);
            acc = rdy_def;
            @(posedge clk); #1;
          end
        end
        valid_i = 1'b0;
      end
      begin : rdy_ctl
        for (int c = 0; c < 12; c++) begin
          ready_i = !(c >= 2 && c <= 8);
          @(negedge clk);
          if (c >= 2 && c <= 8)
            chk($sformatf("bp_ready_o_c%0d", c), 32'(rdy_def), 32'(c == 2));
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
      end
      begin : col
        int got = 0;
        int cyc = 0;
        while (got < 6 && cyc < 60) begin
          @(negedge clk);
          cyc++;
          if (vo_def) begin
            chk($sformatf("bp_fp_w%0d", got), fp_def, bp_exp[got]);
            if (ready_i) got++;
          end
        end
        chk("bp_count", 32'(got), 32'd6);
        repeat (4) begin
          @(negedge clk);
          chk("bp_no_extra", 32'(vo_def), 32'd0);
        end
      end
    join
    @(posedge clk); #1;

    // Reset with three words in flight and the output stalled.
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sign_i  = bp_sgn[i];
      mag     = bp_mag[i];
      valid_i = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    chk("rst_mid_full", 32'(vo_def), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_valid", 32'({vo_def, vo_rne, vo_trc}), 32'd0);
    chk("rst_mid_fp", fp_def | fp_rne | fp_trc, 32'd0);
    chk("rst_mid_ready", 32'({rdy_def, rdy_rne, rdy_trc}), 32'd7);
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_quiet_%0d", i), 32'({vo_def, vo_rne, vo_trc}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fixed_to_fp_pipe.md
Name: fixed_to_fp_pipe

Overview:
- Pipelined, parametrised converter from sign-magnitude fixed point (INT_W integer bits, FRAC_W fraction bits) to IEEE-754 single precision.
- Generalises the existing combinational [-1,1] converter:
  - arbitrary integer range and fraction width
  - selectable rounding
  - valid/ready streaming with full backpressure
- Sits between the fixed-point datapath (CORDIC/accumulator outputs) and the float consumers (Nios custom-instruction result bus, FP FIFOs).

Parameters:
- INT_W, 1, integer magnitude bits; 0..32.
- FRAC_W, 19, fraction bits; 1..100. Together with INT_W, this guarantees no overflow and no denormal outputs.
- ROUND_MODE, 1, rounding mode: 0 = truncate toward zero; 1 = round-to-nearest-even.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- valid_i  in  1  input word valid.
- ready_o  out  1  converter can accept a word this cycle.
- sign_i  in  1  sign; 1 = negative.
- mag_i  in  INT_W+FRAC_W  magnitude; binary point between bit FRAC_W and bit FRAC_W-1.
- valid_o  out  1  fp_o valid.
- ready_i  in  1  downstream accepts fp_o this cycle.
- fp_o  out  32  IEEE-754 result.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-high (reset sampled on rising clk).
  - During/after reset: all stage valid bits = 0, valid_o = 0, fp_o = 32'h0. ready_o is 1 in the first cycle after reset deasserts.
- Handshake:
  - Transfer in on valid_i & ready_o; transfer out on valid_o & ready_i.
  - Once valid_o is high, fp_o and valid_o stay stable until accepted.
- Pipeline: 3 stages (S1, S2, S3); S3 drives the outputs directly from registers.
  - Stage k advances when it is empty or stage k+1 advances. S3 advances when ready_i = 1 or S3 is empty.
  - ready_o = ~S1.valid | S1.advance. This combinational path from ready_i is permitted.
  - Latency: 3 cycles, from the accept edge to valid_o, when there is no backpressure. Throughput: 1 word/cycle.
  - Bubbles collapse: a stalled output must not stall empty upstream stages.
- S1, capture + leading-one detect:
  - Register sign and mag.
  - p = index of the most-significant 1 in mag.
  - zero flag = (mag == 0).
- S2, normalise:
  - exp = 127 + p - FRAC_W (8-bit result; no overflow within the parameter limits).
  - Left-shift mag so that bit p is dropped and the following bits left-justify into a 23-bit mantissa field.
  - Bits below that field become guard bit G and sticky bit S (OR of all remaining bits).
  - If p < 23, the mantissa is zero-padded and G = S = 0.
- S3, round + pack:
  - ROUND_MODE 0: mantissa unchanged.
  - ROUND_MODE 1: increment the mantissa when G & (S | mant[0]).
  - Mantissa carry-out (all ones + 1): mantissa = 0, exp + 1.
  - fp = {sign, exp, mant}.
- Zero: mag == 0 gives fp_o = 32'h0000_0000 regardless of sign (no -0.0).
- Reset mid-operation clears all in-flight words. No output appears for words accepted before reset.
- Simultaneous in/out transfers in a full pipeline are legal and lossless.

Decomposition:
- Package fp_pkg:
  - FP_BIAS = 127
  - FP_EXP_W = 8
  - FP_MANT_W = 23
  - ROUND_TRUNC = 0, ROUND_RNE = 1
  - typedef fp32_t (sign, exp, mant fields)
- Sub-module lead_one_detect:
  - parametrised width W.
  - outputs pos [$clog2(W)-1:0] and zero flag.
  - purely combinational, instantiated in S1.

Test Plan:
- Default params, sign=0, mag=20'h80000 (1.0) -> fp_o = 32'h3F80_0000, valid_o 3 cycles after accept.
- Default params, sign=1, mag=20'h40000 (-0.5) -> 32'hBF00_0000. mag=20'h00001 -> 32'h3600_0000. sign=1, mag=0 -> 32'h0000_0000.
- Rounding, INT_W=2, FRAC_W=30, mag=32'hFFFF_FFFF:
  - ROUND_MODE=1 -> 32'h4080_0000 (carry into exponent).
  - ROUND_MODE=0 -> 32'h407F_FFFF.
- Round-to-nearest-even ties, INT_W=2, FRAC_W=30, ROUND_MODE=1:
  - mag=32'h8000_0080 (tie, mant LSB=0) -> 32'h4000_0000.
  - mag=32'h8000_0180 (tie, LSB=1) -> 32'h4000_0002.
- Backpressure:
  - Stimulus: stream 6 words back-to-back with ready_i=0 for cycles 2..8.
  - Response: ready_o falls once 3 words are held; fp_o stays stable while stalled; all 6 results emerge in order with no drops or duplicates after ready_i rises.
- Reset mid-stream:
  - Stimulus: assert reset with 3 words in flight.
  - Response: next cycle valid_o=0 and fp_o=0; none of the 3 words is ever output; ready_o=1 after reset deasserts.
